traffic_phase_controller: RTL and testbench

Parametrised successor to the fixed five-light intersection controller. It serves NUM_PHASES mutually exclusive signal phases, with round-robin fairness, programmable min/max green, yellow and all-red intervals, emergency preemption and a night flash mode. It sits between the sensor inputs and the lamp drivers, and uses the colors encoding from light_package: red=2'b00, yellow=2'b01, green=2'b10.

---
 rtl/traffic_phase_controller.sv | 207 ++++++++++++++++++++
 tb/tb_traffic_phase_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// Round-robin signal controller for NUM_PHASES exclusive phases with min/max green,
// yellow and all-red clearance, emergency preemption and night flash.
module traffic_phase_controller #(
  parameter int NUM_PHASES    = 4,
  parameter int GREEN_MIN     = 3,
  parameter int GREEN_MAX     = 5,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int FLASH_HALF    = 4,
  parameter int PW            = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PHASES-1:0]   phase_sensor,
  input  logic                    preempt,
  input  logic [PW-1:0]           preempt_phase,
  input  logic                    flash_mode,
  output logic [2*NUM_PHASES-1:0] phase_light,
  output logic [PW-1:0]           active_phase,
  output logic                    phase_active,
  output logic                    in_flash
);

  localparam int M1 = (GREEN_MAX > YELLOW_CYCLES) ? GREEN_MAX : YELLOW_CYCLES;
  localparam int M2 = (M1 > ALLRED_CYCLES) ? M1 : ALLRED_CYCLES;
  localparam int M3 = (M2 > FLASH_HALF) ? M2 : FLASH_HALF;
  localparam int CW = $clog2(M3 + 1);

  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] GMIN_C = CW'(GREEN_MIN);
  localparam logic [CW-1:0] GMAX_C = CW'(GREEN_MAX);
  localparam logic [CW-1:0] YEL_C  = CW'(YELLOW_CYCLES);
  localparam logic [CW-1:0] AR_C   = CW'(ALLRED_CYCLES);
  localparam logic [CW-1:0] FH_C   = CW'(FLASH_HALF);

  localparam logic [1:0] COL_RED    = 2'b00;
  localparam logic [1:0] COL_YELLOW = 2'b01;
  localparam logic [1:0] COL_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    S_HOLD_RED,
    S_GREEN,
    S_YELLOW,
    S_ALL_RED,
    S_FLASH
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   cur_q, cur_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic            blink_q, blink_d;

  // First requester at or after ptr, wrapping; rotation keeps the scan order fair.
  function automatic logic [PW-1:0] pick(input logic [NUM_PHASES-1:0] req,
                                         input logic [PW-1:0] ptr);
    logic [2*NUM_PHASES-1:0] dbl;
    logic [PW-1:0]           w;
    logic                    found;
    dbl   = {req, req} >> ptr;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (!found && dbl[i]) begin
        w     = PW'((int'(ptr) + i) % NUM_PHASES);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  logic [PW-1:0]         win;
  logic [NUM_PHASES-1:0] own_mask;
  logic                  own_req, other_req;
  state_t                arb_state;
  logic [PW-1:0]         arb_cur, arb_rr;
  logic                  take_arb, leave_green;

  always_comb begin
    win = pick(phase_sensor, rr_q);
    own_mask = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (PW'(i) == cur_q) own_mask[i] = 1'b1;
    end
    own_req   = |(phase_sensor & own_mask);
    other_req = |(phase_sensor & ~own_mask);

    // Shared by HOLD_RED and the last all-red cycle: flash > preempt > sensors.
    arb_state = S_HOLD_RED;
    arb_cur   = cur_q;
    arb_rr    = rr_q;
    if (flash_mode) begin
      arb_state = S_FLASH;
    end else if (preempt) begin
      arb_state = S_GREEN;
      arb_cur   = preempt_phase;
    end else if (|phase_sensor) begin
      arb_state = S_GREEN;
      arb_cur   = win;
      arb_rr    = PW'((int'(win) + 1) % NUM_PHASES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HOLD_RED;
      cur_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    blink_d  = blink_q;
    take_arb = 1'b0;
    leave_green = flash_mode
               || (preempt && (preempt_phase != cur_q))
               || (!preempt && (cnt_q >= GMIN_C) && !own_req)
               || (!preempt && (cnt_q >= GMAX_C) && other_req);

    unique case (state_q)
      S_HOLD_RED: take_arb = 1'b1;
      S_GREEN: begin
        if (leave_green) begin
          state_d = S_YELLOW;
          cnt_d   = ONE_C;
        end else if (cnt_q < GMAX_C) begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_YELLOW: begin
        if (cnt_q == YEL_C) begin
          state_d = S_ALL_RED;
          cnt_d   = ONE_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_ALL_RED: begin
        if (cnt_q == AR_C) take_arb = 1'b1;
        else cnt_d = cnt_q + ONE_C;
      end
      S_FLASH: begin
        if (!flash_mode) begin
          state_d = S_ALL_RED;
          cnt_d   = ONE_C;
          blink_d = 1'b0;
        end else if (bcnt_q == FH_C) begin
          blink_d = ~blink_q;
          bcnt_d  = ONE_C;
        end else begin
          bcnt_d = bcnt_q + ONE_C;
        end
      end
      default: state_d = S_HOLD_RED;
    endcase

    if (take_arb) begin
      state_d = arb_state;
      cur_d   = arb_cur;
      rr_d    = arb_rr;
      cnt_d   = (arb_state == S_HOLD_RED) ? '0 : ONE_C;
      if (arb_state == S_FLASH) begin
        blink_d = 1'b1;
        bcnt_d  = ONE_C;
      end
    end
  end

  always_comb begin
    phase_light  = {NUM_PHASES{COL_RED}};
    active_phase = '0;
    phase_active = 1'b0;
    in_flash     = 1'b0;
    unique case (state_q)
      S_GREEN, S_YELLOW: begin
        for (int i = 0; i < NUM_PHASES; i++) begin
          if (PW'(i) == cur_q)
            phase_light[2*i +: 2] = (state_q == S_GREEN) ? COL_GREEN : COL_YELLOW;
        end
        active_phase = cur_q;
        phase_active = 1'b1;
      end
      S_FLASH: begin
        in_flash = 1'b1;
        if (blink_q) phase_light = {NUM_PHASES{COL_YELLOW}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: directed scenarios then random traffic,
// every cycle compared against an interval-based reference model.
module tb_traffic_phase_controller;
  localparam int N    = 4;
  localparam int GMIN = 3;
  localparam int GMAX = 5;
  localparam int YC   = 2;
  localparam int ARC  = 1;
  localparam int FH   = 4;
  localparam int PW   = 2;

  localparam int M_IDLE  = 0;
  localparam int M_GREEN = 1;
  localparam int M_YEL   = 2;
  localparam int M_CLEAR = 3;
  localparam int M_FLASH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic [N-1:0]    sens  = '0;
  logic            pre   = 1'b0;
  logic [PW-1:0]   pp    = '0;
  logic            fl    = 1'b0;
  logic [2*N-1:0]  light;
  logic [PW-1:0]   act;
  logic            pact, infl;

  traffic_phase_controller #(
    .NUM_PHASES(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_CYCLES(YC), .ALLRED_CYCLES(ARC), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .reset(reset), .phase_sensor(sens), .preempt(pre),
    .preempt_phase(pp), .flash_mode(fl), .phase_light(light),
    .active_phase(act), .phase_active(pact), .in_flash(infl)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: current interval kind, which phase owns it, and its age in cycles.
  int m_mode = M_IDLE;
  int m_age  = 0;
  int m_cur  = 0;
  int m_rr   = 0;

  function automatic int winner(input int req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (((req >> ((ptr + i) % N)) & 1) != 0) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_arb();
    int w;
    if (fl) begin
      m_mode = M_FLASH; m_age = 1;
    end else if (pre) begin
      m_mode = M_GREEN; m_cur = int'(pp); m_age = 1;
    end else if (sens != 0) begin
      w = winner(int'(sens), m_rr);
      m_mode = M_GREEN; m_cur = w; m_rr = (w + 1) % N; m_age = 1;
    end else begin
      m_mode = M_IDLE; m_age = 0;
    end
  endtask

  task automatic model_step();
    int sv;
    sv = int'(sens);
    if (reset) begin
      m_mode = M_IDLE; m_cur = 0; m_rr = 0; m_age = 0;
    end else begin
      case (m_mode)
        M_IDLE: model_arb();
        M_GREEN: begin
          if (fl || (pre && int'(pp) != m_cur)
              || (!pre && m_age >= GMIN && ((sv >> m_cur) & 1) == 0)
              || (!pre && m_age >= GMAX && (sv & ~(1 << m_cur)) != 0)) begin
            m_mode = M_YEL; m_age = 1;
          end else m_age++;
        end
        M_YEL: begin
          if (m_age >= YC) begin m_mode = M_CLEAR; m_age = 1; end
          else m_age++;
        end
        M_CLEAR: begin
          if (m_age >= ARC) model_arb();
          else m_age++;
        end
        default: begin
          if (!fl) begin m_mode = M_CLEAR; m_age = 1; end
          else m_age++;
        end
      endcase
    end
  endtask

  function automatic int exp_light();
    int v;
    v = 0;
    if (m_mode == M_GREEN) v = 2 << (2 * m_cur);
    else if (m_mode == M_YEL) v = 1 << (2 * m_cur);
    else if (m_mode == M_FLASH && (((m_age - 1) / FH) % 2) == 0)
      for (int i = 0; i < N; i++) v |= 1 << (2 * i);
    return v;
  endfunction

  task automatic cyc(input logic r, input logic [N-1:0] s, input logic p,
                     input logic [PW-1:0] ppx, input logic f);
    int nr;
    int busy;
    @(negedge clk);
    reset = r; sens = s; pre = p; pp = ppx; fl = f;
    @(posedge clk);
    model_step();
    #1;
    busy = (m_mode == M_GREEN || m_mode == M_YEL) ? 1 : 0;
    check("phase_light", int'(light), exp_light());
    check("active_phase", int'(act), busy ? m_cur : 0);
    check("phase_active", int'(pact), busy);
    check("in_flash", int'(infl), (m_mode == M_FLASH) ? 1 : 0);
    nr = 0;
    for (int i = 0; i < N; i++) if (light[2*i +: 2] != 2'b00) nr++;
    if (!infl) check("one_nonred", (nr <= 1) ? 1 : 0, 1);
  endtask

  int g, y;
  logic [N-1:0]  rs;
  logic          rp, rf;
  logic [PW-1:0] rpp;

  initial begin
    // Single short request on phase 2: exact min green, yellow, all-red.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("reset_light", int'(light), 0);
    cyc(0, 4'b0100, 0, 0, 0);
    g = (light[5:4] == 2'b10) ? 1 : 0; y = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 0, 0, 0);
      if (light[5:4] == 2'b10) g++;
      if (light[5:4] == 2'b01) y++;
    end
    check("s1_green_len", g, 3);
    check("s1_yellow_len", y, 2);
    cyc(0, 4'b1001, 0, 0, 0);
    check("s1_rr_after", int'(act), 3);

    // Two competing phases alternate at max green.
    cyc(1, 0, 0, 0, 0);
    g = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 4'b0011, 0, 0, 0);
      if (light[1:0] == 2'b10) g++;
    end
    check("s2_p0_green", g, GMAX);
    g = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 4'b0011, 0, 0, 0);
      if (light[3:2] == 2'b10) g++;
    end
    check("s2_p1_green", g, GMAX);
    cyc(0, 4'b0011, 0, 0, 0);
    check("s2_p0_again", int'(light[1:0]), 2);

    // Lone requester holds green indefinitely.
    cyc(1, 0, 0, 0, 0);
    g = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 4'b1000, 0, 0, 0);
      if (light[7:6] == 2'b10) g++;
    end
    check("s3_hold", g, 20);
    cyc(0, 0, 0, 0, 0);
    check("s3_drop_yellow", int'(light[7:6]), 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);

    // Preempt another phase at green cnt=1.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 4'b0010, 0, 0, 0);
    cyc(0, 0, 1, 2, 0);
    check("s4_yellow", int'(light[3:2]), 1);
    for (int k = 0; k < 12; k++) cyc(0, 4'b0010, 1, 2, 0);
    check("s4_hold", int'(act), 2);
    for (int k = 0; k < 12; k++) cyc(0, 4'b0011, 0, 0, 0);

    // Flash request mid green.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 4'b0001, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 4'b0001, 0, 0, 1);
    y = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(0, 4'b0001, 0, 0, 1);
      if (light == 8'h55) y++;
    end
    check("s5_flash_yel", y, 8);
    cyc(0, 4'b0001, 0, 0, 0);
    check("s5_exit_red", int'(light), 0);
    cyc(0, 4'b0001, 0, 0, 0);
    check("s5_rearb", int'(light[1:0]), 2);

    // Reset during yellow.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 4'b0001, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0);
    cyc(1, 4'hF, 0, 0, 0);
    check("s6_reset_light", int'(light), 0);
    check("s6_reset_act", int'(act), 0);
    cyc(0, 4'hF, 0, 0, 0);
    check("s6_resume", int'(light[1:0]), 2);

    // Random traffic.
    rs = '0; rp = 1'b0; rf = 1'b0; rpp = '0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7, 0) == 0) rs = N'($urandom_range(15, 0));
      if ($urandom_range(39, 0) == 0) begin
        rp  = ~rp;
        rpp = PW'($urandom_range(N - 1, 0));
      end
      if ($urandom_range(79, 0) == 0) rf = ~rf;
      cyc($urandom_range(299, 0) == 0, rs, rp, rpp, rf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
